// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32I opcodes, ALU op encoding, immediate
// formats and the registered control bundle.
package decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    jump;
    logic    alu_src;
    logic    illegal;
  } ctrl_t;

  // alt selects SUB/SRA; callers decide when bit 30 is meaningful
  function automatic alu_op_e alu_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:0] ins, input imm_fmt_e fmt);
    case (fmt)
      IMM_I:   return {{20{ins[31]}}, ins[31:20]};
      IMM_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   return {ins[31:12], 12'b0};
      IMM_J:   return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two combinational read ports, one write port,
// x0 hardwired to zero, asynchronous active-low clear.
module regfile_2r1w #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            gclk,
  input  logic            grst_n,
  input  logic            i_we,
  input  logic [AW-1:0]   i_wa,
  input  logic [XLEN-1:0] i_wd,
  input  logic [AW-1:0]   i_ra1,
  input  logic [AW-1:0]   i_ra2,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2
);

  logic [XLEN-1:0] r_mem [1:NREG-1];

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      for (int i = 1; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we && (i_wa != '0)) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_ra1 == '0) ? '0 : r_mem[i_ra1];
  assign o_rd2 = (i_ra2 == '0) ? '0 : r_mem[i_ra2];

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register, field/control/immediate decode, operand
// read. Define DECODE_WB_BYPASS_EN to forward same-edge write-back to operands.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            instr_valid_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            wb_en_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [XLEN-1:0] imm_o,
  output logic [4:0]      rd_o,
  output logic [2:0]      funct3_o,
  output logic [3:0]      alu_op_o,
  output logic            reg_write_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            branch_o,
  output logic            jump_o,
  output logic            alu_src_o,
  output logic            illegal_o
);

  logic [6:0]      w_op;
  logic [2:0]      w_f3;
  logic [4:0]      w_rs1_idx, w_rs2_idx, w_rd;
  logic [XLEN-1:0] w_rf_rd1, w_rf_rd2, w_rs1_val, w_rs2_val, w_imm;
  logic            w_wb_live;
  ctrl_t           w_ctrl;
  imm_fmt_e        w_fmt;

  logic            r_valid;
  logic [XLEN-1:0] r_pc, r_rs1, r_rs2, r_imm;
  logic [4:0]      r_rd, r_rs1_idx, r_rs2_idx;
  logic [2:0]      r_f3;
  ctrl_t           r_ctrl;

  assign w_op      = instr_i[6:0];
  assign w_f3      = instr_i[14:12];
  assign w_rs1_idx = instr_i[19:15];
  assign w_rs2_idx = instr_i[24:20];
  assign w_wb_live = wb_en_i && (wb_rd_i != 5'd0);

  regfile_2r1w #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .gclk  (clk),
    .grst_n(reset),
    .i_we  (wb_en_i),
    .i_wa  (wb_rd_i),
    .i_wd  (wb_data_i),
    .i_ra1 (w_rs1_idx),
    .i_ra2 (w_rs2_idx),
    .o_rd1 (w_rf_rd1),
    .o_rd2 (w_rf_rd2)
  );

`ifdef DECODE_WB_BYPASS_EN
  assign w_rs1_val = (w_wb_live && (wb_rd_i == w_rs1_idx)) ? wb_data_i : w_rf_rd1;
  assign w_rs2_val = (w_wb_live && (wb_rd_i == w_rs2_idx)) ? wb_data_i : w_rf_rd2;
`else
  assign w_rs1_val = w_rf_rd1;
  assign w_rs2_val = w_rf_rd2;
`endif

  always_comb begin
    w_ctrl = '0;
    w_fmt  = IMM_NONE;
    w_rd   = instr_i[11:7];
    case (w_op)
      OP_R: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_op    = alu_f3(w_f3, instr_i[30]);
      end
      OP_IMM: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        // bit 30 is immediate data except for the shift-right encodings
        w_ctrl.alu_op    = alu_f3(w_f3, (w_f3 == 3'd5) && instr_i[30]);
        w_fmt            = IMM_I;
      end
      OP_LOAD: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_fmt            = IMM_I;
      end
      OP_STORE: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_fmt            = IMM_S;
        w_rd             = 5'd0;
      end
      OP_BRANCH: begin
        w_ctrl.branch = 1'b1;
        w_ctrl.alu_op = ALU_SUB;
        w_fmt         = IMM_B;
        w_rd          = 5'd0;
      end
      OP_JAL: begin
        w_ctrl.jump      = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_fmt            = IMM_J;
      end
      OP_JALR: begin
        w_ctrl.jump      = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_fmt            = IMM_I;
      end
      OP_LUI: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_op    = ALU_PASSB;
        w_fmt            = IMM_U;
      end
      OP_AUIPC: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_fmt            = IMM_U;
      end
      default: w_ctrl.illegal = 1'b1;
    endcase
    if (!instr_valid_i) w_ctrl = '0;
  end

  assign w_imm = imm_gen(instr_i, w_fmt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0; r_pc <= '0; r_rs1 <= '0; r_rs2 <= '0; r_imm <= '0;
      r_rd <= '0; r_f3 <= '0; r_ctrl <= '0; r_rs1_idx <= '0; r_rs2_idx <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0; r_pc <= '0; r_rs1 <= '0; r_rs2 <= '0; r_imm <= '0;
      r_rd <= '0; r_f3 <= '0; r_ctrl <= '0; r_rs1_idx <= '0; r_rs2_idx <= '0;
    end else if (stall_i) begin
      // keep held operands coherent with a write-back landing on them
      if (w_wb_live && (wb_rd_i == r_rs1_idx)) r_rs1 <= wb_data_i;
      if (w_wb_live && (wb_rd_i == r_rs2_idx)) r_rs2 <= wb_data_i;
    end else begin
      r_valid   <= instr_valid_i;
      r_pc      <= pc_i;
      r_rs1     <= w_rs1_val;
      r_rs2     <= w_rs2_val;
      r_imm     <= w_imm;
      r_rd      <= w_rd;
      r_f3      <= w_f3;
      r_ctrl    <= w_ctrl;
      r_rs1_idx <= w_rs1_idx;
      r_rs2_idx <= w_rs2_idx;
    end
  end

  assign valid_o     = r_valid;
  assign pc_o        = r_pc;
  assign rs1_data_o  = r_rs1;
  assign rs2_data_o  = r_rs2;
  assign imm_o       = r_imm;
  assign rd_o        = r_rd;
  assign funct3_o    = r_f3;
  assign alu_op_o    = r_ctrl.alu_op;
  assign reg_write_o = r_ctrl.reg_write;
  assign mem_read_o  = r_ctrl.mem_read;
  assign mem_write_o = r_ctrl.mem_write;
  assign branch_o    = r_ctrl.branch;
  assign jump_o      = r_ctrl.jump;
  assign alu_src_o   = r_ctrl.alu_src;
  assign illegal_o   = r_ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: driver predicts each registered bundle
// from an instruction-level model; a monitor compares every cycle.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_i, pc_i, wb_data_i;
  logic        instr_valid_i, stall_i, flush_i, wb_en_i;
  logic [4:0]  wb_rd_i;
  logic        valid_o, reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o, alu_src_o, illegal_o;
  logic [31:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
  logic [4:0]  rd_o;
  logic [2:0]  funct3_o;
  logic [3:0]  alu_op_o;

  decode_stage dut (
    .clk(clk), .reset(reset), .instr_i(instr_i), .pc_i(pc_i),
    .instr_valid_i(instr_valid_i), .stall_i(stall_i), .flush_i(flush_i),
    .wb_en_i(wb_en_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .valid_o(valid_o), .pc_o(pc_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .imm_o(imm_o), .rd_o(rd_o), .funct3_o(funct3_o), .alu_op_o(alu_op_o),
    .reg_write_o(reg_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .branch_o(branch_o), .jump_o(jump_o), .alu_src_o(alu_src_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1, rs2, imm;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic        rw, mr, mw, br, jp, src, ill;
  } bun_t;

  int          total = 0;
  int          bad   = 0;
  bun_t        sb_q[$];
  bun_t        m_cur;
  logic [4:0]  m_i1, m_i2;
  logic [31:0] m_rf [32];
  logic        rst_lvl;
  bun_t        mon_exp, mon_act;

  function automatic bun_t dut_bun();
    return {valid_o, pc_o, rs1_data_o, rs2_data_o, imm_o, rd_o, funct3_o, alu_op_o,
            reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o, alu_src_o, illegal_o};
  endfunction

  // Instruction-level reference: fields, controls and immediate straight from the ISA rules
  function automatic bun_t ref_decode(input logic [31:0] ins, input logic [31:0] pc, input bit v);
    bun_t        b;
    int          base[8];
    logic [2:0]  f3;
    logic [6:0]  op;
    logic [31:0] sgn, imm_i, imm_s, imm_b, imm_j, imm_u;
    base  = '{0, 2, 3, 4, 5, 6, 8, 9};
    op    = ins[6:0];
    f3    = ins[14:12];
    sgn   = ins[31] ? 32'hFFFF_FFFF : 32'h0;
    imm_i = $signed(ins) >>> 20;
    imm_s = (imm_i & ~32'h1F) | 32'(ins[11:7]);
    imm_b = (sgn << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    imm_j = (sgn << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
    imm_u = ins & 32'hFFFF_F000;
    b = '0;
    b.valid = v; b.pc = pc; b.rd = ins[11:7]; b.f3 = f3;
    case (op)
      7'h33: begin b.rw = 1; b.alu = 4'(base[f3] + ((ins[30] && (f3 == 0 || f3 == 5)) ? 1 : 0)); end
      7'h13: begin b.rw = 1; b.src = 1; b.imm = imm_i; b.alu = 4'(base[f3] + ((ins[30] && f3 == 5) ? 1 : 0)); end
      7'h03: begin b.rw = 1; b.mr = 1; b.src = 1; b.imm = imm_i; end
      7'h23: begin b.mw = 1; b.src = 1; b.imm = imm_s; b.rd = 0; end
      7'h63: begin b.br = 1; b.alu = 1; b.imm = imm_b; b.rd = 0; end
      7'h6F: begin b.jp = 1; b.rw = 1; b.imm = imm_j; end
      7'h67: begin b.jp = 1; b.rw = 1; b.src = 1; b.imm = imm_i; end
      7'h37: begin b.rw = 1; b.src = 1; b.alu = 10; b.imm = imm_u; end
      7'h17: begin b.rw = 1; b.src = 1; b.imm = imm_u; end
      default: b.ill = 1;
    endcase
    if (!v) begin
      b.rw = 0; b.mr = 0; b.mw = 0; b.br = 0; b.jp = 0; b.src = 0; b.ill = 0; b.alu = 0;
    end
    return b;
  endfunction

  function automatic void model_clear();
    m_cur = '0; m_i1 = 0; m_i2 = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
  endfunction

  function automatic void model_edge(input logic [31:0] ins, input logic [31:0] pc, input bit v,
                                     input bit st, input bit fl, input bit we,
                                     input logic [4:0] wr, input logic [31:0] wd);
    bit hit;
    if (!rst_lvl) begin
      model_clear();
      return;
    end
    hit = we && (wr != 0);
    if (fl) begin
      m_cur = '0; m_i1 = 0; m_i2 = 0;
    end else if (st) begin
      if (hit && wr == m_i1) m_cur.rs1 = wd;
      if (hit && wr == m_i2) m_cur.rs2 = wd;
    end else begin
      m_cur = ref_decode(ins, pc, v);
      m_i1 = ins[19:15];
      m_i2 = ins[24:20];
      m_cur.rs1 = m_rf[m_i1];
      m_cur.rs2 = m_rf[m_i2];
`ifdef DECODE_WB_BYPASS_EN
      if (hit && wr == m_i1) m_cur.rs1 = wd;
      if (hit && wr == m_i2) m_cur.rs2 = wd;
`endif
    end
    if (hit) m_rf[wr] = wd;
  endfunction

  task automatic cyc(input logic [31:0] ins, input logic [31:0] pc, input bit v, input bit st,
                     input bit fl, input bit we, input logic [4:0] wr, input logic [31:0] wd);
    @(negedge clk);
    reset = rst_lvl; instr_i = ins; pc_i = pc; instr_valid_i = v; stall_i = st;
    flush_i = fl; wb_en_i = we; wb_rd_i = wr; wb_data_i = wd;
    model_edge(ins, pc, v, st, fl, we, wr, wd);
    sb_q.push_back(m_cur);
    @(posedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, 32'(valid_o), 0);
    chk({nm, "_pc"}, pc_o, 0);
    chk({nm, "_rs"}, rs1_data_o | rs2_data_o, 0);
    chk({nm, "_imm"}, imm_o, 0);
    chk({nm, "_ctl"}, 32'({reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o, alu_src_o, illegal_o, alu_op_o, rd_o}), 0);
  endtask

  // asserted between edges: outputs must clear without waiting for a clock
  task automatic async_rst(input string nm);
    #2;
    reset = 1'b0; rst_lvl = 1'b0;
    model_clear();
    #1;
    chk_zero(nm);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_exp = sb_q.pop_front();
      mon_act = dut_bun();
      total++;
      if (mon_act !== mon_exp) begin
        bad++;
        $display("FAIL bundle t=%0t got=%h want=%h", $time, mon_act, mon_exp);
      end
    end
  end

  function automatic logic [31:0] rnd_instr();
    logic [6:0]  ops[9];
    logic [31:0] ins;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    ins = $urandom;
    if ($urandom_range(0, 9) != 0) ins[6:0] = ops[$urandom_range(0, 8)];
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    return ins;
  endfunction

  initial begin
    reset = 1'b1; rst_lvl = 1'b1;
    instr_i = 0; pc_i = 0; instr_valid_i = 0; stall_i = 0; flush_i = 0;
    wb_en_i = 0; wb_rd_i = 0; wb_data_i = 0;
    model_clear();
    async_rst("rst0");
    cyc(32'h0, 32'h0, 0, 0, 0, 0, 0, 0);
    rst_lvl = 1'b1;

    // addi x1,x0,5
    cyc(32'h0050_0093, 32'h100, 1, 0, 0, 0, 0, 0);
    #2;
    chk("addi_imm", imm_o, 5);
    chk("addi_rd", 32'(rd_o), 1);
    chk("addi_alu", 32'(alu_op_o), 0);
    chk("addi_ctl", 32'({valid_o, reg_write_o, alu_src_o, mem_read_o, illegal_o}), 32'b11100);

    // add x3,x1,x2 after write-back of x1/x2
    cyc(32'h0, 32'h0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF);
    cyc(32'h0, 32'h0, 0, 0, 0, 1, 2, 32'h1);
    cyc(32'h0020_81B3, 32'h104, 1, 0, 0, 0, 0, 0);
    #2;
    chk("add_rs1", rs1_data_o, 32'hDEAD_BEEF);
    chk("add_rs2", rs2_data_o, 32'h1);
    chk("add_rd", 32'(rd_o), 3);

    // same-edge write to rs1
    cyc(32'h0020_81B3, 32'h108, 1, 0, 0, 1, 1, 32'h1234_5678);
    #2;
`ifdef DECODE_WB_BYPASS_EN
    chk("same_edge_rs1", rs1_data_o, 32'h1234_5678);
`else
    chk("same_edge_rs1", rs1_data_o, 32'hDEAD_BEEF);
`endif

    // stall: write-back to held rs1 refreshes it, everything else frozen
    cyc($urandom, $urandom, 1, 1, 0, 1, 1, 32'hCAFE_F00D);
    #2;
    chk("stall_rs1_refresh", rs1_data_o, 32'hCAFE_F00D);
    chk("stall_pc", pc_o, 32'h108);
    cyc($urandom, $urandom, 1, 1, 0, 0, 0, 0);
    cyc($urandom, $urandom, 0, 1, 0, 0, 0, 0);
    #2;
    chk("stall_hold_pc", pc_o, 32'h108);
    chk("stall_hold_rd", 32'(rd_o), 3);

    // flush beats stall; its write-back still lands
    cyc($urandom, $urandom, 1, 1, 1, 1, 4, 32'h44);
    #2;
    chk("flush_valid", 32'(valid_o), 0);
    cyc(32'h0002_03B3, 32'h10C, 1, 0, 0, 0, 0, 0);
    #2;
    chk("flush_wb_x4", rs1_data_o, 32'h44);

    // x0 stays zero; beq x0,x0,-8
    cyc(32'h0, 32'h0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF);
    cyc(32'hFE00_0CE3, 32'h200, 1, 0, 0, 0, 0, 0);
    #2;
    chk("beq_rs1", rs1_data_o, 0);
    chk("beq_imm", imm_o, 32'hFFFF_FFF8);
    chk("beq_ctl", 32'({branch_o, reg_write_o, alu_op_o}), 32'b1_0_0001);

    // illegal opcode, valid then invalid
    cyc(32'hFFFF_FFFF, 32'h204, 1, 0, 0, 0, 0, 0);
    #2;
    chk("ill_flag", 32'(illegal_o), 1);
    chk("ill_ctl", 32'({reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o, alu_src_o}), 0);
    cyc(32'hFFFF_FFFF, 32'h208, 0, 0, 0, 0, 0, 0);
    #2;
    chk("ill_inv", 32'({illegal_o, valid_o}), 0);

    for (int n = 0; n < 400; n++) begin
      cyc(rnd_instr(), $urandom, $urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
    end

    // mid-stream reset: pending bundle dropped, regfile cleared, writes ignored while low
    cyc(32'h0050_0093, 32'h300, 1, 0, 0, 1, 5, 32'h55);
    async_rst("rst_mid");
    cyc(32'h0, 32'h0, 0, 0, 0, 1, 5, 32'h77);
    rst_lvl = 1'b1;
    cyc(32'h0002_8333, 32'h304, 1, 0, 0, 0, 0, 0);
    #2;
    chk("rst_x5", rs1_data_o, 0);

    for (int n = 0; n < 100; n++) begin
      cyc(rnd_instr(), $urandom, $urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
    end

    repeat (3) @(posedge clk);
    #3;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: left=%0d want=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
